operand_collector: RTL and testbench



---
 rtl/operand_collector.sv | 153 +++++++++++++++
 tb/tb_operand_collector.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_collector.sv
// Single operand collector: latches one dispatched instruction, reads its source operands from the banked RF, hands it to the EU.
// Optional BGPU_OPC_ZERO_REG_EN: register 0 reads as zero without a bank request.
module operand_collector #(
   parameter int unsigned NumTags         = 8,
   parameter int unsigned PcWidth         = 32,
   parameter int unsigned NumWarps        = 8,
   parameter int unsigned WarpWidth       = 32,
   parameter int unsigned RegIdxWidth     = 6,
   parameter int unsigned OperandsPerInst = 2,
   parameter int unsigned NumBanks        = 4,
   parameter int unsigned RegWidth        = 32,
   localparam int unsigned TagWidth       = $clog2(NumTags),
   localparam int unsigned WidWidth       = $clog2(NumWarps),
   localparam int unsigned IidWidth       = TagWidth + WidWidth,
   localparam int unsigned BankSelWidth   = $clog2(NumBanks),
   localparam int unsigned BankAddrWidth  = WidWidth + RegIdxWidth - BankSelWidth
) (
   input  logic                                            clk_i,
   input  logic                                            rst_ni,
   output logic                                            opc_ready_o,
   input  logic                                            disp_valid_i,
   input  logic [IidWidth-1:0]                             disp_tag_i,
   input  logic [PcWidth-1:0]                              disp_pc_i,
   input  logic [WarpWidth-1:0]                            disp_act_mask_i,
   input  logic [RegIdxWidth-1:0]                          disp_dst_i,
   input  logic [OperandsPerInst-1:0][RegIdxWidth-1:0]     disp_src_i,
   output logic [OperandsPerInst-1:0]                      read_req_valid_o,
   input  logic [OperandsPerInst-1:0]                      read_req_ready_i,
   output logic [OperandsPerInst-1:0][BankSelWidth-1:0]    read_req_bank_sel_o,
   output logic [OperandsPerInst-1:0][BankAddrWidth-1:0]   read_req_addr_o,
   input  logic [OperandsPerInst-1:0]                      read_rsp_valid_i,
   input  logic [OperandsPerInst-1:0][RegWidth-1:0]        read_rsp_data_i,
   output logic                                            eu_valid_o,
   input  logic                                            eu_ready_i,
   output logic [IidWidth-1:0]                             eu_tag_o,
   output logic [PcWidth-1:0]                              eu_pc_o,
   output logic [WarpWidth-1:0]                            eu_act_mask_o,
   output logic [RegIdxWidth-1:0]                          eu_dst_o,
   output logic [OperandsPerInst-1:0][RegWidth-1:0]        eu_operands_o
);

   localparam int unsigned GWidth = WidWidth + RegIdxWidth;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] COLLECT = 2'd1;
   localparam logic [1:0] DONE    = 2'd2;

   logic [1:0]                                    state_q;
   logic [OperandsPerInst-1:0]                    req_pending_q;
   logic [OperandsPerInst-1:0]                    have_q;
   logic [OperandsPerInst-1:0]                    have_next;
   logic [OperandsPerInst-1:0]                    zero_src;
   logic [OperandsPerInst-1:0][GWidth-1:0]        glob_idx;
   logic [OperandsPerInst-1:0][BankSelWidth-1:0]  disp_bank;
   logic [OperandsPerInst-1:0][BankAddrWidth-1:0] disp_addr;

   // Low bits of {wid, reg} pick the bank so consecutive registers of a warp spread across banks.
   always_comb begin
      glob_idx  = '0;
      disp_bank = '0;
      disp_addr = '0;
      for (int i = 0; i < OperandsPerInst; i++) begin
         glob_idx[i]  = {disp_tag_i[TagWidth +: WidWidth], disp_src_i[i]};
         disp_bank[i] = glob_idx[i][BankSelWidth-1:0];
         disp_addr[i] = glob_idx[i][GWidth-1:BankSelWidth];
      end
   end

`ifdef BGPU_OPC_ZERO_REG_EN
   always_comb begin
      zero_src = '0;
      for (int i = 0; i < OperandsPerInst; i++) begin
         zero_src[i] = (disp_src_i[i] == '0);
      end
   end
`else
   assign zero_src = '0;
`endif

   // Responses arriving this cycle count toward completion so DONE is entered without an extra cycle.
   assign have_next = have_q | (read_rsp_valid_i & ~have_q);

   assign opc_ready_o      = (state_q == IDLE);
   assign eu_valid_o       = (state_q == DONE);
   assign read_req_valid_o = req_pending_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q             <= IDLE;
         req_pending_q       <= '0;
         have_q              <= '0;
         read_req_bank_sel_o <= '0;
         read_req_addr_o     <= '0;
         eu_tag_o            <= '0;
         eu_pc_o             <= '0;
         eu_act_mask_o       <= '0;
         eu_dst_o            <= '0;
         eu_operands_o       <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (disp_valid_i) begin
                  eu_tag_o            <= disp_tag_i;
                  eu_pc_o             <= disp_pc_i;
                  eu_act_mask_o       <= disp_act_mask_i;
                  eu_dst_o            <= disp_dst_i;
                  read_req_bank_sel_o <= disp_bank;
                  read_req_addr_o     <= disp_addr;
                  req_pending_q       <= ~zero_src;
                  have_q              <= zero_src;
                  for (int i = 0; i < OperandsPerInst; i++) begin
                     if (zero_src[i]) begin
                        eu_operands_o[i] <= '0;
                     end
                  end
                  state_q <= (&zero_src) ? DONE : COLLECT;
               end
            end
            COLLECT: begin
               req_pending_q <= req_pending_q & ~read_req_ready_i;
               for (int i = 0; i < OperandsPerInst; i++) begin
                  if (read_rsp_valid_i[i] && !have_q[i]) begin
                     eu_operands_o[i] <= read_rsp_data_i[i];
                  end
               end
               have_q <= have_next;
               if (&have_next) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               if (eu_ready_i) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifndef SYNTHESIS
   // Unexpected responses are dropped by the datapath; this only makes them visible in simulation.
   always @(posedge clk_i) begin
      if (rst_ni) begin
         for (int i = 0; i < OperandsPerInst; i++) begin
            assert (!(read_rsp_valid_i[i] && ((state_q == IDLE) || have_q[i])))
               else $warning("operand_collector: unexpected read response on port %0d ignored", i);
         end
      end
   end
`endif

endmodule

// File: tb/tb_operand_collector.sv
// Self-checking bench for operand_collector: directed scenarios plus randomized transactions against a cycle-level reference model.
module tb_operand_collector;

   localparam int NumTags         = 8;
   localparam int PcWidth         = 32;
   localparam int NumWarps        = 8;
   localparam int WarpWidth       = 32;
   localparam int RegIdxWidth     = 6;
   localparam int OperandsPerInst = 2;
   localparam int NumBanks        = 4;
   localparam int RegWidth        = 32;
   localparam int IidWidth        = 6;
   localparam int BankSelWidth    = 2;
   localparam int BankAddrWidth   = 7;
   localparam int NumRegs         = 64;

   logic                                           clk;
   logic                                           rst_n;
   logic                                           opc_ready;
   logic                                           disp_valid;
   logic [IidWidth-1:0]                            disp_tag;
   logic [PcWidth-1:0]                             disp_pc;
   logic [WarpWidth-1:0]                           disp_mask;
   logic [RegIdxWidth-1:0]                         disp_dst;
   logic [OperandsPerInst-1:0][RegIdxWidth-1:0]    disp_src;
   logic [OperandsPerInst-1:0]                     req_valid;
   logic [OperandsPerInst-1:0]                     req_ready;
   logic [OperandsPerInst-1:0][BankSelWidth-1:0]   req_bank;
   logic [OperandsPerInst-1:0][BankAddrWidth-1:0]  req_addr;
   logic [OperandsPerInst-1:0]                     rsp_valid;
   logic [OperandsPerInst-1:0][RegWidth-1:0]       rsp_data;
   logic                                           eu_valid;
   logic                                           eu_ready;
   logic [IidWidth-1:0]                            eu_tag;
   logic [PcWidth-1:0]                             eu_pc;
   logic [WarpWidth-1:0]                           eu_mask;
   logic [RegIdxWidth-1:0]                         eu_dst;
   logic [OperandsPerInst-1:0][RegWidth-1:0]       eu_ops;

   logic [RegWidth-1:0] bankMem [0:NumWarps*NumRegs-1];
   int total = 0;
   int bad   = 0;

   operand_collector #(
      .NumTags(NumTags), .PcWidth(PcWidth), .NumWarps(NumWarps), .WarpWidth(WarpWidth),
      .RegIdxWidth(RegIdxWidth), .OperandsPerInst(OperandsPerInst), .NumBanks(NumBanks),
      .RegWidth(RegWidth)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .opc_ready_o(opc_ready),
      .disp_valid_i(disp_valid), .disp_tag_i(disp_tag), .disp_pc_i(disp_pc),
      .disp_act_mask_i(disp_mask), .disp_dst_i(disp_dst), .disp_src_i(disp_src),
      .read_req_valid_o(req_valid), .read_req_ready_i(req_ready),
      .read_req_bank_sel_o(req_bank), .read_req_addr_o(req_addr),
      .read_rsp_valid_i(rsp_valid), .read_rsp_data_i(rsp_data),
      .eu_valid_o(eu_valid), .eu_ready_i(eu_ready), .eu_tag_o(eu_tag), .eu_pc_o(eu_pc),
      .eu_act_mask_o(eu_mask), .eu_dst_o(eu_dst), .eu_operands_o(eu_ops)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit zeroSkipped(input int src);
`ifdef BGPU_OPC_ZERO_REG_EN
      return (src == 0);
`else
      return 1'b0;
`endif
   endfunction

   // One instruction from dispatch to EU handshake; called at a negedge while the collector is idle.
   // stallN: cycles port N's ready stays low; dlyN: extra bank latency; euHold: cycles eu_ready stays low.
   task automatic applyStimulus(input int wid, input int src0, input int src1,
                                input int stall0, input int stall1,
                                input int dly0, input int dly1, input int euHold);
      int src[2], stl[2], dly[2], acc[2], rsp[2], gidx[2];
      bit skip[2];
      logic [RegWidth-1:0] expOp[2];
      logic [IidWidth-1:0] tag;
      logic [PcWidth-1:0] pc;
      logic [WarpWidth-1:0] mask;
      logic [RegIdxWidth-1:0] dst;
      int doneCyc, hsCyc;
      bit expValid, inDone;
      src[0] = src0; src[1] = src1;
      stl[0] = stall0; stl[1] = stall1;
      dly[0] = dly0; dly[1] = dly1;
      doneCyc = 1;
      for (int i = 0; i < 2; i++) begin
         gidx[i]  = wid * NumRegs + src[i];
         skip[i]  = zeroSkipped(src[i]);
         acc[i]   = 1 + stl[i];
         rsp[i]   = acc[i] + 1 + dly[i];
         expOp[i] = skip[i] ? '0 : bankMem[gidx[i]];
         if (!skip[i] && rsp[i] + 1 > doneCyc) doneCyc = rsp[i] + 1;
      end
      hsCyc = doneCyc + euHold;
      tag  = IidWidth'(wid * NumTags + $urandom_range(0, NumTags - 1));
      pc   = $urandom;
      mask = $urandom;
      dst  = RegIdxWidth'($urandom);

      checkOutput("opc_ready_at_dispatch", 64'(opc_ready), 64'd1);
      disp_valid  = 1'b1;
      disp_tag    = tag;
      disp_pc     = pc;
      disp_mask   = mask;
      disp_dst    = dst;
      disp_src[0] = RegIdxWidth'(src[0]);
      disp_src[1] = RegIdxWidth'(src[1]);
      req_ready   = '0;
      rsp_valid   = '0;
      eu_ready    = 1'b0;
      @(negedge clk);
      disp_valid = 1'b0;
      for (int c = 1; c <= hsCyc + 1; c++) begin
         for (int i = 0; i < 2; i++) begin
            expValid = !skip[i] && (c <= acc[i]);
            checkOutput($sformatf("req_valid%0d_c%0d", i, c), 64'(req_valid[i]), 64'(expValid));
            if (expValid) begin
               checkOutput($sformatf("req_bank%0d_c%0d", i, c), 64'(req_bank[i]), 64'(gidx[i] % NumBanks));
               checkOutput($sformatf("req_addr%0d_c%0d", i, c), 64'(req_addr[i]), 64'(gidx[i] / NumBanks));
            end
         end
         inDone = (c >= doneCyc) && (c <= hsCyc);
         checkOutput($sformatf("eu_valid_c%0d", c), 64'(eu_valid), 64'(inDone));
         checkOutput($sformatf("opc_ready_c%0d", c), 64'(opc_ready), 64'(c > hsCyc));
         if (inDone) begin
            checkOutput("eu_tag", 64'(eu_tag), 64'(tag));
            checkOutput("eu_pc", 64'(eu_pc), 64'(pc));
            checkOutput("eu_mask", 64'(eu_mask), 64'(mask));
            checkOutput("eu_dst", 64'(eu_dst), 64'(dst));
            checkOutput("eu_op0", 64'(eu_ops[0]), 64'(expOp[0]));
            checkOutput("eu_op1", 64'(eu_ops[1]), 64'(expOp[1]));
         end
         for (int i = 0; i < 2; i++) begin
            req_ready[i] = (c >= acc[i]);
            rsp_valid[i] = !skip[i] && (c == rsp[i]);
            rsp_data[i]  = rsp_valid[i] ? bankMem[gidx[i]] : RegWidth'($urandom);
         end
         eu_ready = (c >= hsCyc);
         if (c <= hsCyc) @(negedge clk);
      end
      rsp_valid = '0;
   endtask

   initial begin
      int w, s0, s1;
      rst_n      = 1'b0;
      disp_valid = 1'b0;
      disp_tag   = '0;
      disp_pc    = '0;
      disp_mask  = '0;
      disp_dst   = '0;
      disp_src   = '0;
      req_ready  = '1;
      rsp_valid  = '0;
      rsp_data   = '0;
      eu_ready   = 1'b0;
      for (int i = 0; i < NumWarps * NumRegs; i++) bankMem[i] = $urandom;
      bankMem[3*NumRegs+5] = 32'hA;
      bankMem[3*NumRegs+2] = 32'hB;

      $display("[TB] reset values");
      repeat (2) @(negedge clk);
      checkOutput("rst_opc_ready", 64'(opc_ready), 64'd1);
      checkOutput("rst_req_valid", 64'(req_valid), 64'd0);
      checkOutput("rst_eu_valid", 64'(eu_valid), 64'd0);
      checkOutput("rst_eu_tag", 64'(eu_tag), 64'd0);
      checkOutput("rst_eu_ops", 64'(eu_ops), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] basic collection");
      applyStimulus(3, 5, 2, 0, 0, 0, 0, 0);
      $display("[TB] request stall");
      applyStimulus(1, 10, 11, 3, 0, 0, 0, 0);
      $display("[TB] out-of-order responses");
      applyStimulus(4, 6, 7, 0, 0, 2, 0, 0);
      $display("[TB] execution unit backpressure");
      applyStimulus(5, 12, 13, 0, 0, 0, 0, 4);
      $display("[TB] zero register");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(6, 0, 3, 1, 0, 0, 1, 1);
      applyStimulus(2, 8, 12, 0, 2, 1, 0, 0);

      $display("[TB] reset mid-collect");
      disp_valid  = 1'b1;
      disp_tag    = 6'd17;
      disp_src[0] = 6'd7;
      disp_src[1] = 6'd9;
      req_ready   = '0;
      @(negedge clk);
      disp_valid = 1'b0;
      checkOutput("midrst_req_valid_before", 64'(req_valid), 64'd3);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_req_valid", 64'(req_valid), 64'd0);
      checkOutput("midrst_opc_ready", 64'(opc_ready), 64'd1);
      checkOutput("midrst_eu_valid", 64'(eu_valid), 64'd0);
      checkOutput("midrst_eu_ops", 64'(eu_ops), 64'd0);
      @(negedge clk);
      rst_n       = 1'b1;
      rsp_valid   = 2'b11;
      rsp_data[0] = 32'hDEAD_BEEF;
      rsp_data[1] = 32'h1234_5678;
      @(negedge clk);
      rsp_valid = '0;
      checkOutput("late_rsp_opc_ready", 64'(opc_ready), 64'd1);
      checkOutput("late_rsp_eu_valid", 64'(eu_valid), 64'd0);
      checkOutput("late_rsp_req_valid", 64'(req_valid), 64'd0);
      checkOutput("late_rsp_eu_ops", 64'(eu_ops), 64'd0);
      applyStimulus(2, 7, 9, 0, 0, 0, 0, 0);

      $display("[TB] randomized transactions");
      for (int n = 0; n < 40; n++) begin
         w  = $urandom_range(0, NumWarps - 1);
         s0 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, NumRegs - 1);
         s1 = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, NumRegs - 1);
         applyStimulus(w, s0, s1, $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
